// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage registers: slot-state encoding,
// the MIPS no-op word and the payload widths used at each stage boundary.
package pipe_pkg;

  // Encoding matches {s_valid, m_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // IF/ID: {pc_plus4, instruction}
  localparam int unsigned IFID_W  = 64;
  // ID/EX: {pc_plus4, rs_val, rt_val, imm, rt, rd}
  localparam int unsigned IDEX_W  = 32 * 4 + 5 * 2;
  // EX/MEM: {alu_result, store_data, dest_reg}
  localparam int unsigned EXMEM_W = 32 * 2 + 5;
  // MEM/WB: {mem_data, alu_result, dest_reg}
  localparam int unsigned MEMWB_W = 32 * 2 + 5;

  localparam int unsigned SB_W_DEFAULT = 2;

  function automatic logic [1:0] occ_count(input logic m, input logic s);
    return {1'b0, m} + {1'b0, s};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One register slot {valid, data, sb}. Clear wins over load; an invalid slot
// always holds the NOP payload and a zero sideband.
module pipe_slot #(
  parameter int unsigned           DATA_W    = 64,
  parameter int unsigned           SB_W      = 2,
  parameter logic [DATA_W-1:0]     NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [SB_W-1:0]   load_sb,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [SB_W-1:0]   sb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= NOP_VALUE;
      sb    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= NOP_VALUE;
      sb    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      sb    <= load_sb;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, a 2-entry skid
// buffer (registered in_ready), synchronous flush and occupancy count.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       SB_W      = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SB_W-1:0]   in_sb,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SB_W-1:0]   out_sb,
  output logic [1:0]        occupancy
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [SB_W-1:0]   m_sb, s_sb;

  logic              m_load, m_clear, m_from_skid;
  logic              s_load, s_clear;
  logic [DATA_W-1:0] m_load_data;
  logic [SB_W-1:0]   m_load_sb;

  logic   accept, pop;
  state_t state, next_state;

  // The state register is the pair of slot valid bits.
  pipe_slot #(
    .DATA_W    (DATA_W),
    .SB_W      (SB_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (m_load),
    .clear     (m_clear),
    .load_data (m_load_data),
    .load_sb   (m_load_sb),
    .valid     (m_valid),
    .data      (m_data),
    .sb        (m_sb)
  );

  pipe_slot #(
    .DATA_W    (DATA_W),
    .SB_W      (SB_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (s_load),
    .clear     (s_clear),
    .load_data (in_data),
    .load_sb   (in_sb),
    .valid     (s_valid),
    .data      (s_data),
    .sb        (s_sb)
  );

  assign state    = state_t'({s_valid, m_valid});
  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = m_valid & out_ready;

  always_comb begin
    next_state = state;
    case (state)
      ST_EMPTY: next_state = accept ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        case ({pop, accept})
          2'b11:   next_state = ST_ONE;
          2'b10:   next_state = ST_EMPTY;
          2'b01:   next_state = ST_FULL;
          default: next_state = ST_ONE;
        endcase
      end
      ST_FULL:  next_state = pop ? ST_ONE : ST_FULL;
      default:  next_state = ST_EMPTY;
    endcase
    if (flush) next_state = ST_EMPTY;
  end

  always_comb begin
    m_load      = 1'b0;
    m_from_skid = 1'b0;
    s_load      = 1'b0;
    case (state)
      ST_EMPTY: m_load = accept;
      ST_ONE: begin
        m_load = pop & accept;
        s_load = accept & ~pop;
      end
      ST_FULL: begin
        m_load      = pop;
        m_from_skid = 1'b1;
      end
      default: ;
    endcase
    // Clearing whenever the slot will be invalid keeps NOP_VALUE in empty slots
    // and also recovers from the unreachable {s=1, m=0} encoding.
    m_clear     = (next_state == ST_EMPTY);
    s_clear     = (next_state != ST_FULL);
    m_load_data = m_from_skid ? s_data : in_data;
    m_load_sb   = m_from_skid ? s_sb : in_sb;
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_sb    = m_sb;
  assign occupancy = occ_count(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model of the
// stage: up to two words held in order, ready whenever fewer than two are held.
module tb_pipe_stage_reg;

  localparam logic [63:0] NOP = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [1:0]  in_sb = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [1:0]  out_sb;
  logic [1:0]  occupancy;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [65:0] q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W    (64),
    .SB_W      (2),
    .NOP_VALUE (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sb     (in_sb),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sb    (out_sb),
    .occupancy (occupancy)
  );

  function automatic logic [63:0] exp_data();
    return (q.size() > 0) ? q[0][63:0] : NOP;
  endfunction

  function automatic logic [1:0] exp_sb();
    return (q.size() > 0) ? q[0][65:64] : 2'b00;
  endfunction

  // Drives one cycle of inputs and advances the model; samples happen 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic [1:0] s,
                       input logic ordy, input logic fl);
    bit do_pop, do_acc;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_sb     = s;
    out_ready = ordy;
    flush     = fl;
    do_pop = (q.size() > 0) && ordy;
    do_acc = v && (q.size() < 2);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back({s, d});
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== NOP) begin bad++; $display("FAIL reset_out_data got=%h exp=%h", out_data, NOP); end
    total++; if (out_sb !== 2'b00) begin bad++; $display("FAIL reset_out_sb got=%b exp=00", out_sb); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stream();
    logic [63:0] words [3];
    words[0] = 64'h4; words[1] = 64'h8; words[2] = 64'hC;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, words[i], 2'(i), 1'b1, 1'b0);
      total++; if (out_valid !== 1'b1 || out_data !== words[i]) begin
        bad++; $display("FAIL stream_word%0d got=%b/%h exp=1/%h", i, out_valid, out_data, words[i]);
      end
      total++; if (occupancy !== 2'd1 || out_sb !== 2'(i)) begin
        bad++; $display("FAIL stream_occ%0d got=%0d/%b exp=1/%b", i, occupancy, out_sb, 2'(i));
      end
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin
      bad++; $display("FAIL stream_drain got=%b/%h/%0d exp=0/%h/0", out_valid, out_data, occupancy, NOP);
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 64'h10, 2'b01, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_first got=%0d/%b exp=1/1", occupancy, in_ready);
    end
    cycle(1'b1, 64'h14, 2'b10, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_full got=%0d/%b exp=2/0", occupancy, in_ready);
    end
    total++; if (out_data !== 64'h10 || out_sb !== 2'b01 || out_valid !== 1'b1) begin
      bad++; $display("FAIL stall_hold got=%h/%b exp=10/01", out_data, out_sb);
    end
    // Upstream keeps offering while full; the word must be refused.
    cycle(1'b1, 64'h99, 2'b11, 1'b0, 1'b0);
    total++; if (out_data !== 64'h10 || occupancy !== 2'd2) begin
      bad++; $display("FAIL stall_refuse got=%h/%0d exp=10/2", out_data, occupancy);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (out_data !== 64'h14 || out_sb !== 2'b10 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      bad++; $display("FAIL stall_pop1 got=%h/%b/%0d exp=14/1/1", out_data, in_ready, occupancy);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      bad++; $display("FAIL stall_pop2 got=%b/%b/%0d exp=0/1/0", out_valid, in_ready, occupancy);
    end
  endtask

  task automatic test_flush_full();
    cycle(1'b1, 64'h20, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 64'h24, 2'b01, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_setup got=%0d exp=2", occupancy); end
    cycle(1'b1, 64'h28, 2'b11, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== NOP || out_sb !== 2'b00) begin
      bad++; $display("FAIL flush_empty got=%b/%0d/%h exp=0/0/%h", out_valid, occupancy, out_data, NOP);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      total++; if (out_valid !== 1'b0 || out_data === 64'h28) begin
        bad++; $display("FAIL flush_discard%0d got=%b/%h exp=0/%h", i, out_valid, out_data, NOP);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 64'h30, 2'b01, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 64'h30) begin
      bad++; $display("FAIL areset_setup got=%b/%h exp=1/30", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== NOP) begin
      bad++; $display("FAIL areset_immediate got=%b/%b/%0d/%h exp=0/1/0/%h",
                      out_valid, in_ready, occupancy, out_data, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int unsigned errs = 0;
    int unsigned pops = 0;
    for (int n = 0; n < 10000; n++) begin
      logic v, r, f;
      logic [63:0] d;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 63) == 0);
      d = {$urandom, $urandom};
      if (q.size() > 0 && r && !f) pops++;
      cycle(v, d, 2'($urandom_range(0, 3)), r, f);
      total++;
      if (out_valid !== (q.size() > 0) || out_data !== exp_data() || out_sb !== exp_sb() ||
          occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2) ||
          (out_valid === 1'b0 && occupancy !== 2'd0)) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d got=%b/%h/%b/%0d/%b exp=%b/%h/%b/%0d/%b", n,
                   out_valid, out_data, out_sb, occupancy, in_ready,
                   q.size() > 0, exp_data(), exp_sb(), q.size(), q.size() < 2);
      end
    end
    total++; if (pops == 0) begin bad++; $display("FAIL random_activity got=%0d exp=>0", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_async_reset();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipelined MIPS core. It is the generic successor to the fixed IF/ID latch and is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake, a 2-entry skid buffer so that upstream ready is registered, synchronous flush (bubble insertion) and an occupancy count. Payload and sideband widths are parameters, so one module serves every stage boundary.

## Interface
- DATA_W, 64, payload width (e.g. {PC+4, instruction} at IF/ID)
- SB_W, 2, sideband flag width (e.g. {branch, stall} flags)
- NOP_VALUE, 64'h0, payload value while empty, after reset and after flush (instruction 0 = sll $0,$0,0)
- clk  in  1  stage clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word present
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_data  in  DATA_W  upstream payload
- in_sb  in  SB_W  upstream sideband
- flush  in  1  synchronous kill of all held and incoming words (branch taken / hazard squash)
- out_valid  out  1  main slot holds a word
- out_ready  in  1  downstream accepts; low = stall
- out_data  out  DATA_W  main slot payload
- out_sb  out  SB_W  main slot sideband
- occupancy  out  2  words held, 0..2

## Operation
- Storage: main slot {m_valid, m_data, m_sb} drives the outputs directly; skid slot {s_valid, s_data, s_sb}.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- States, derived from the valid bits:
  - EMPTY: m=0, s=0
  - ONE: m=1, s=0
  - FULL: m=1, s=1
  - m=0 with s=1 is illegal and must never occur.
- EMPTY: accept -> ONE, main <= input.
- ONE:
  - pop & accept -> ONE, main <= input.
  - pop only -> EMPTY.
  - accept only (stalled) -> FULL, skid <= input, main holds.
  - neither -> hold.
- FULL: in_ready=0, so no accept. pop -> ONE, main <= skid. No pop -> hold.
- flush (highest priority): next state EMPTY. Both valid bits are cleared, both data registers load NOP_VALUE and sideband loads 0. A word presented the same cycle is discarded. A pop occurring in the same cycle still completes downstream.
- While a slot is invalid, its data register holds NOP_VALUE (outputs are never X).
- occupancy = m_valid + s_valid.
- No combinational path from out_ready to in_ready.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, out_data=NOP_VALUE, out_sb=0, occupancy=0. Skid data is also NOP_VALUE.
- Deassertion of rst_n is synchronous to clk, handled externally. The first accept is possible on the first rising edge after release.
- Latency: a word accepted at edge N is visible on out_data after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while out_ready is high.
- in_ready falls the cycle after the stage becomes FULL. It rises the cycle after the pop out of FULL.
- Stall: with out_ready low, out_data/out_sb are stable and out_valid stays high until the pop. Upstream may present a new word and is not required to hold in_valid stable.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- flush and rst_n give identical resulting state. flush is edge-sampled; rst_n is level, asynchronous.

## Structure
- Shared package pipe_pkg:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd3, matching {s_valid, m_valid}
  - MIPS_NOP = 32'h0000_0000
  - per-boundary width constants (IFID_W=64, IDEX_W, ...)
- One sub-module, pipe_slot: a single register slot {valid, data, sb} with load/clear controls. It is instantiated twice (main, skid); control logic lives in the parent.
- No memories; flops only.

## Test plan
- Reset/idle: hold rst_n low 2 cycles, release. Require out_valid=0, in_ready=1, out_data=0, occupancy=0.
- Streaming: out_ready=1, push in_data=0x4,0x8,0xC on consecutive cycles. Require out_data 0x4,0x8,0xC one cycle later each, occupancy=1, no gaps.
- Stall/skid: out_ready=0, push 0x10 then 0x14. Require occupancy=2, then in_ready=0, out_data=0x10 held. Raise out_ready for 2 cycles. Require 0x10 then 0x14 out in order, then in_ready=1.
- Flush while FULL: state FULL holding 0x20/0x24, assert flush with in_valid=1, in_data=0x28. Next cycle require out_valid=0, occupancy=0, out_data=NOP_VALUE; 0x28 is never output.
- Async reset mid-stream: drop rst_n between clock edges while in ONE. Require out_valid=0 and in_ready=1 before the next edge.
- Random valid/ready with a scoreboard, 10k cycles: output order equals input order, no loss or duplication, and m=0/s=1 never observed.
